demod_conj_mult_mc: RTL and testbench



---
 rtl/demod_conj_mult_pkg.sv | 22 ++
 rtl/demod_hist_rf.sv | 37 +++
 rtl/demod_conj_mult_mc.sv | 127 ++++++++++++
 tb/tb_demod_conj_mult_mc.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demod_conj_mult_pkg.sv
// rtl/demod_conj_mult_pkg.sv - shared constants and helpers for the conjugate-multiply front end
package demod_conj_mult_pkg;

  localparam int DEFAULT_QUANT_BITS = 10;
  localparam int MAX_PROD_W         = 128;
  localparam int MAX_CH_W           = 4;

  typedef logic [MAX_CH_W-1:0] ch_tag_t;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Arithmetic shift keeps the floor behaviour of negative products.
  function automatic logic signed [MAX_PROD_W-1:0] dequantize(
    input logic signed [MAX_PROD_W-1:0] value,
    input int                           quant_bits
  );
    return value >>> quant_bits;
  endfunction

endpackage

// File: rtl/demod_hist_rf.sv
// rtl/demod_hist_rf.sv - per-channel previous-sample store, async read, sync write and clear
module demod_hist_rf #(
  parameter int NUM_CH = 1,
  parameter int WIDTH  = 64,
  parameter int CH_W   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CH_W-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [NUM_CH];

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset || clear) begin
        mem[c] <= '0;
      end else if (wr_en && (wr_addr == CH_W'(c))) begin
        mem[c] <= wr_data;
      end
    end
  end

  // Mux by compare so an address wider than the entry count never indexes out of range.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_addr == CH_W'(c)) rd_data = mem[c];
    end
  end

endmodule

// File: rtl/demod_conj_mult_mc.sv
// rtl/demod_conj_mult_mc.sv - multi-channel pipelined cur*conj(prev) with paired r/i output FIFOs
module demod_conj_mult_mc
  import demod_conj_mult_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  QUANT_BITS = DEFAULT_QUANT_BITS,
  parameter int  NUM_CH     = 1,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_hist,
  output logic                  inA_rd_en,
  input  logic                  inA_empty,
  input  logic [DATA_WIDTH-1:0] inA_dout,
  output logic                  inB_rd_en,
  input  logic                  inB_empty,
  input  logic [DATA_WIDTH-1:0] inB_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out2_wr_en,
  input  logic                  out2_full,
  output logic [DATA_WIDTH-1:0] out2_din,
  output logic [CH_W-1:0]       out_ch
);

  localparam int PW = 2 * DATA_WIDTH;

  logic                         rd_fire, write_fire;
  logic                         s1_valid, s2_valid, s1_ready, s2_ready;
  logic [CH_W-1:0]              ch_idx, s1_tag, s2_tag;
  logic [2*DATA_WIDTH-1:0]      hist_rd;
  logic signed [DATA_WIDTH-1:0] rp, ip, re, im;
  logic signed [PW-1:0]         rp_x, ip_x, re_x, im_x;
  logic signed [PW-1:0]         s1_p0, s1_p1, s1_p2, s1_p3;
  logic signed [DATA_WIDTH-1:0] t0, t1, t2, t3;
  logic signed [DATA_WIDTH-1:0] s2_r, s2_i;

  // Reset also gates the handshakes so nothing is popped or pushed while held.
  assign write_fire = s2_valid && !out_full && !out2_full && !reset;
  assign s2_ready   = !s2_valid || write_fire;
  assign s1_ready   = !s1_valid || s2_ready;
  assign rd_fire    = !inA_empty && !inB_empty && !clear_hist && s1_ready && !reset;

  assign inA_rd_en  = rd_fire;
  assign inB_rd_en  = rd_fire;

  demod_hist_rf #(
    .NUM_CH (NUM_CH),
    .WIDTH  (2 * DATA_WIDTH),
    .CH_W   (CH_W)
  ) u_hist (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear_hist),
    .wr_en   (rd_fire),
    .wr_addr (ch_idx),
    .wr_data ({inA_dout, inB_dout}),
    .rd_addr (ch_idx),
    .rd_data (hist_rd)
  );

  assign rp   = hist_rd[2*DATA_WIDTH-1:DATA_WIDTH];
  assign ip   = hist_rd[DATA_WIDTH-1:0];
  assign re   = inA_dout;
  assign im   = inB_dout;
  assign rp_x = PW'(rp);
  assign ip_x = PW'(ip);
  assign re_x = PW'(re);
  assign im_x = PW'(im);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      ch_idx   <= '0;
      s1_p0    <= '0;
      s1_p1    <= '0;
      s1_p2    <= '0;
      s1_p3    <= '0;
    end else begin
      if (s1_ready) s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_p0  <= rp_x * re_x;
        s1_p1  <= -(ip_x * im_x);
        s1_p2  <= rp_x * im_x;
        s1_p3  <= -(ip_x * re_x);
        s1_tag <= ch_idx;
      end
      if (clear_hist) begin
        ch_idx <= '0;
      end else if (rd_fire) begin
        ch_idx <= (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
      end
    end
  end

  // Each term is truncated to the word width before combining; the sum wraps.
  assign t0 = DATA_WIDTH'(dequantize(MAX_PROD_W'(s1_p0), QUANT_BITS));
  assign t1 = DATA_WIDTH'(dequantize(MAX_PROD_W'(s1_p1), QUANT_BITS));
  assign t2 = DATA_WIDTH'(dequantize(MAX_PROD_W'(s1_p2), QUANT_BITS));
  assign t3 = DATA_WIDTH'(dequantize(MAX_PROD_W'(s1_p3), QUANT_BITS));

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_i     <= '0;
      s2_tag   <= '0;
    end else begin
      if (s2_ready) s2_valid <= s1_valid;
      if (s2_ready && s1_valid) begin
        s2_r   <= t0 - t1;
        s2_i   <= t2 + t3;
        s2_tag <= s1_tag;
      end
    end
  end

  assign out_wr_en  = write_fire;
  assign out2_wr_en = write_fire;
  assign out_din    = write_fire ? s2_r : '0;
  assign out2_din   = write_fire ? s2_i : '0;
  assign out_ch     = write_fire ? s2_tag : '0;

endmodule

// File: tb/tb_demod_conj_mult_mc.sv
// tb/tb_demod_conj_mult_mc.sv - scoreboard bench driving a 1-channel and a 2-channel instance in lockstep
`timescale 1ns/1ps
module tb_demod_conj_mult_mc;

  localparam int DW = 32;
  localparam int Q  = 10;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic [0:0]    ch;
    int            cyc;
  } res_t;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } smp_t;

  logic          clock      = 1'b0;
  logic          reset      = 1'b1;
  logic          clear_hist = 1'b0;
  logic          inA_empty  = 1'b1;
  logic          inB_empty  = 1'b1;
  logic          out_full   = 1'b0;
  logic          out2_full  = 1'b0;
  logic [DW-1:0] inA_dout   = '0;
  logic [DW-1:0] inB_dout   = '0;

  logic          rd_a [2];
  logic          rd_b [2];
  logic          wr   [2];
  logic          wr2  [2];
  logic [DW-1:0] dr   [2];
  logic [DW-1:0] di   [2];
  logic [0:0]    dch  [2];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic strict   = 1'b0;
  logic no_read  = 1'b0;
  logic no_write = 1'b0;

  smp_t   in_q [$];
  res_t   sb   [2][$];
  res_t   wlog [2][$];
  longint hre  [2][2];
  longint him  [2][2];
  int     chi  [2];

  always #5 clock = ~clock;

  demod_conj_mult_mc #(.DATA_WIDTH(DW), .QUANT_BITS(Q), .NUM_CH(1)) dut_a (
    .clock(clock), .reset(reset), .clear_hist(clear_hist),
    .inA_rd_en(rd_a[0]), .inA_empty(inA_empty), .inA_dout(inA_dout),
    .inB_rd_en(rd_b[0]), .inB_empty(inB_empty), .inB_dout(inB_dout),
    .out_wr_en(wr[0]), .out_full(out_full), .out_din(dr[0]),
    .out2_wr_en(wr2[0]), .out2_full(out2_full), .out2_din(di[0]),
    .out_ch(dch[0])
  );

  demod_conj_mult_mc #(.DATA_WIDTH(DW), .QUANT_BITS(Q), .NUM_CH(2)) dut_b (
    .clock(clock), .reset(reset), .clear_hist(clear_hist),
    .inA_rd_en(rd_a[1]), .inA_empty(inA_empty), .inA_dout(inA_dout),
    .inB_rd_en(rd_b[1]), .inB_empty(inB_empty), .inB_dout(inB_dout),
    .out_wr_en(wr[1]), .out_full(out_full), .out_din(dr[1]),
    .out2_wr_en(wr2[1]), .out2_full(out2_full), .out2_din(di[1]),
    .out_ch(dch[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic res_t conj_mult(input longint rp, input longint ip, input longint re,
                                     input longint im, input int ch, input int c);
    res_t   e;
    longint a0, a1, a2, a3;
    a0    = (rp * re) >>> Q;
    a1    = ((-ip) * im) >>> Q;
    a2    = (rp * im) >>> Q;
    a3    = ((-ip) * re) >>> Q;
    e.r   = DW'(a0) - DW'(a1);
    e.i   = DW'(a2) + DW'(a3);
    e.ch  = 1'(ch);
    e.cyc = c;
    return e;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      chi[d] = 0;
      for (int c = 0; c < 2; c++) begin
        hre[d][c] = 0;
        him[d][c] = 0;
      end
    end
  endtask

  task automatic refresh();
    inA_empty = (in_q.size() == 0);
    inB_empty = inA_empty;
    if (in_q.size() != 0) begin
      inA_dout = in_q[0].re;
      inB_dout = in_q[0].im;
    end
  endtask

  task automatic push(input logic [DW-1:0] re, input logic [DW-1:0] im);
    smp_t s;
    s.re = re;
    s.im = im;
    in_q.push_back(s);
    refresh();
  endtask

  task automatic cycle();
    res_t e, got;
    smp_t s;
    @(negedge clock);
    check("rd_same_inst", rd_a[1], rd_a[0]);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rd_pair%0d", d), rd_b[d], rd_a[d]);
      check($sformatf("wr_pair%0d", d), wr2[d], wr[d]);
      if (reset || clear_hist || inA_empty) check($sformatf("rd_blocked%0d", d), rd_a[d], 1'b0);
      if (no_read) check($sformatf("stall_rd%0d", d), rd_a[d], 1'b0);
      if (reset || out_full || out2_full || no_write)
        check($sformatf("wr_blocked%0d", d), wr[d], 1'b0);
      if (wr[d] !== 1'b1) begin
        check($sformatf("idle_out%0d", d), 64'(dr[d]) | 64'(di[d]) | 64'(dch[d]), 64'd0);
      end else if (sb[d].size() == 0) begin
        check($sformatf("spurious_wr%0d", d), wr[d], 1'b0);
      end else begin
        e = sb[d].pop_front();
        check($sformatf("r%0d", d), dr[d], e.r);
        check($sformatf("i%0d", d), di[d], e.i);
        check($sformatf("ch%0d", d), dch[d], e.ch);
        if (strict) check($sformatf("latency%0d", d), cyc - e.cyc, 2);
        got.r   = dr[d];
        got.i   = di[d];
        got.ch  = dch[d];
        got.cyc = cyc;
        wlog[d].push_back(got);
      end
    end
    if (reset) begin
      sb[0].delete();
      sb[1].delete();
      model_clear();
    end else if (clear_hist) begin
      model_clear();
    end
    if (rd_a[0] === 1'b1) begin
      if (in_q.size() == 0) begin
        check("read_when_empty", rd_a[0], 1'b0);
      end else begin
        s = in_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          e = conj_mult(hre[d][chi[d]], him[d][chi[d]], longint'($signed(s.re)),
                        longint'($signed(s.im)), chi[d], cyc);
          sb[d].push_back(e);
          hre[d][chi[d]] = longint'($signed(s.re));
          him[d][chi[d]] = longint'($signed(s.im));
          chi[d] = (chi[d] + 1) % (d + 1);
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    refresh();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((in_q.size() != 0 || sb[0].size() != 0 || sb[1].size() != 0) && n < 300) begin
      cycle();
      n++;
    end
    check("drain_in_time", n < 300, 1'b1);
    cycle();
    cycle();
  endtask

  task automatic expect_log(input int d, input int k, input logic [DW-1:0] r,
                            input logic [DW-1:0] i, input logic [0:0] ch);
    if (wlog[d].size() <= k) begin
      check($sformatf("log_len%0d_%0d", d, k), wlog[d].size(), k + 1);
    end else begin
      check($sformatf("dir_r%0d_%0d", d, k), wlog[d][k].r, r);
      check($sformatf("dir_i%0d_%0d", d, k), wlog[d][k].i, i);
      check($sformatf("dir_ch%0d_%0d", d, k), wlog[d][k].ch, ch);
    end
  endtask

  task automatic clear_logs();
    wlog[0].delete();
    wlog[1].delete();
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_rd%0d", d), rd_a[d], 1'b0);
      check($sformatf("rst_wr%0d", d), wr[d], 1'b0);
      check($sformatf("rst_out%0d", d), 64'(dr[d]) | 64'(di[d]) | 64'(dch[d]), 64'd0);
    end

    // Basic products and exact two-cycle latency
    strict = 1'b1;
    clear_logs();
    push(32'd1024, 32'd0);
    push(32'd0, 32'd1024);
    drain();
    expect_log(0, 0, 32'd0, 32'd0, 1'b0);
    expect_log(0, 1, 32'd0, 32'd1024, 1'b0);

    // Floor behaviour of the arithmetic shift on a small negative term
    clear_logs();
    push(32'd0, 32'd1);
    push(32'd0, 32'd1);
    drain();
    expect_log(0, 0, 32'd1, 32'd0, 1'b0);
    expect_log(0, 1, 32'd1, 32'd0, 1'b0);

    // Two interleaved channels from a cleared history
    clear_hist = 1'b1;
    cycle();
    clear_hist = 1'b0;
    clear_logs();
    push(32'd1024, 32'd0);
    push(32'd0, 32'd1024);
    push(32'd0, 32'd1024);
    push(32'd0, 32'd1024);
    drain();
    expect_log(1, 0, 32'd0, 32'd0, 1'b0);
    expect_log(1, 1, 32'd0, 32'd0, 1'b1);
    expect_log(1, 2, 32'd0, 32'd1024, 1'b0);
    expect_log(1, 3, 32'd1024, 32'd0, 1'b1);

    // Backpressure from each output FIFO in turn
    strict = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      clear_logs();
      for (int k = 0; k < 8; k++) push(DW'($urandom), DW'($urandom));
      repeat (3) cycle();
      if (pass == 0) out_full = 1'b1;
      else out2_full = 1'b1;
      no_read = 1'b1;
      repeat (5) cycle();
      no_read   = 1'b0;
      out_full  = 1'b0;
      out2_full = 1'b0;
      drain();
      check($sformatf("bp_count_a%0d", pass), wlog[0].size(), 8);
      check($sformatf("bp_count_b%0d", pass), wlog[1].size(), 8);
    end

    // History clear between samples while two results are in flight
    strict = 1'b1;
    clear_logs();
    for (int k = 0; k < 6; k++) push(DW'($urandom_range(50000, 0)) - 25000, DW'($urandom_range(50000, 0)) - 25000);
    repeat (3) cycle();
    clear_hist = 1'b1;
    cycle();
    clear_hist = 1'b0;
    drain();
    check("clr_count", wlog[0].size(), 6);
    expect_log(0, 3, 32'd0, 32'd0, 1'b0);
    expect_log(1, 3, 32'd0, 32'd0, 1'b0);

    // Reset with both pipeline stages occupied
    for (int k = 0; k < 6; k++) push(DW'($urandom_range(50000, 0)) - 25000, DW'($urandom_range(50000, 0)) - 25000);
    repeat (3) cycle();
    clear_logs();
    reset    = 1'b1;
    no_write = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    no_write = 1'b0;
    drain();
    check("rst_count", wlog[0].size(), 3);
    expect_log(0, 0, 32'd0, 32'd0, 1'b0);
    expect_log(1, 0, 32'd0, 32'd0, 1'b0);
    expect_log(1, 1, 32'd0, 32'd0, 1'b1);

    check("sb_empty", sb[0].size() + sb[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
